// File: rtl/rsp_s2_dma_rd_ctrl.sv
// Burst scheduler for the stage-2 DMA read engine: walks frame/segment/word loops and emits
// one alen descriptor per burst. Optional burst statistics via RSP_S2_DMA_RD_CTRL_STAT_EN.
module rsp_s2_dma_rd_ctrl #(
  parameter int unsigned SLEN_BITS = 16,
  parameter int unsigned SNUM_BITS = 12,
  parameter int unsigned FNUM_BITS = 12,
  parameter int unsigned PB_BITS   = 16,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [SLEN_BITS-1:0] SLEN,
  input  logic [SNUM_BITS-1:0] SNUM,
  input  logic [FNUM_BITS-1:0] FNUM,
  input  logic [PB_BITS-1:0]   PBURSTS,
  output logic                 update,
  output logic                 resume,
  input  logic                 pcnt_finish,
  input  logic                 ccnt_finish,
  output logic                 alen_fifo_push,
  input  logic                 alen_fifo_full,
  output logic [11:0]          alen_fifo_din,
  output logic                 busy,
  output logic                 done
`ifdef RSP_S2_DMA_RD_CTRL_STAT_EN
  ,
  output logic [15:0]          stat_bursts
`endif
);

  localparam logic [SLEN_BITS-1:0] MaxBurst = SLEN_BITS'(MAX_BURST);

  typedef enum logic [2:0] {StIdle, StUpd, StGen, StPwait, StCwait} state_e;

  state_e               state_q;
  logic [SLEN_BITS-1:0] slen_q, rem_q;
  logic [SNUM_BITS-1:0] snum_q, seg_q;
  logic [FNUM_BITS-1:0] fnum_q, frm_q;
  logic [PB_BITS-1:0]   pb_q, pcnt_q;

  logic                 s_last, f_last, c_last, p_hit, p_last;
  logic [SLEN_BITS-1:0] blen;
  logic                 cfg_zero;

  // Descriptor for the burst at the current loop position; bounds compared before increment.
  always_comb begin
    s_last   = (rem_q <= MaxBurst);
    blen     = s_last ? rem_q : MaxBurst;
    f_last   = s_last && (seg_q == snum_q - SNUM_BITS'(1));
    c_last   = f_last && (frm_q == fnum_q - FNUM_BITS'(1));
    p_hit    = (pb_q != '0) && (pcnt_q == pb_q - PB_BITS'(1));
    p_last   = p_hit && !c_last;
    cfg_zero = (SLEN == '0) || (SNUM == '0) || (FNUM == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      slen_q         <= '0;
      rem_q          <= '0;
      snum_q         <= '0;
      seg_q          <= '0;
      fnum_q         <= '0;
      frm_q          <= '0;
      pb_q           <= '0;
      pcnt_q         <= '0;
      update         <= 1'b0;
      resume         <= 1'b0;
      alen_fifo_push <= 1'b0;
      alen_fifo_din  <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
`ifdef RSP_S2_DMA_RD_CTRL_STAT_EN
      stat_bursts    <= '0;
`endif
    end else begin
      update         <= 1'b0;
      resume         <= 1'b0;
      alen_fifo_push <= 1'b0;
      done           <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (cfg_zero) begin
              done <= 1'b1;
            end else begin
              slen_q  <= SLEN;
              snum_q  <= SNUM;
              fnum_q  <= FNUM;
              pb_q    <= PBURSTS;
              rem_q   <= SLEN;
              seg_q   <= '0;
              frm_q   <= '0;
              pcnt_q  <= '0;
              update  <= 1'b1;
              busy    <= 1'b1;
              state_q <= StUpd;
`ifdef RSP_S2_DMA_RD_CTRL_STAT_EN
              stat_bursts <= '0;
`endif
            end
          end
        end
        // The update cycle already decides the first push so it lands one cycle later.
        StUpd, StGen: begin
          state_q <= StGen;
          if (!alen_fifo_full) begin
            alen_fifo_push <= 1'b1;
            alen_fifo_din  <= {s_last, p_last, f_last, c_last, 8'(blen - SLEN_BITS'(1))};
`ifdef RSP_S2_DMA_RD_CTRL_STAT_EN
            if (stat_bursts != 16'hFFFF) stat_bursts <= stat_bursts + 16'd1;
`endif
            if (s_last) begin
              rem_q <= slen_q;
              if (f_last) begin
                seg_q <= '0;
                if (!c_last) frm_q <= frm_q + FNUM_BITS'(1);
              end else begin
                seg_q <= seg_q + SNUM_BITS'(1);
              end
            end else begin
              rem_q <= rem_q - MaxBurst;
            end
            if (pb_q == '0 || p_hit) pcnt_q <= '0;
            else                     pcnt_q <= pcnt_q + PB_BITS'(1);
            if (c_last)      state_q <= StCwait;
            else if (p_last) state_q <= StPwait;
          end
        end
        StPwait: begin
          if (pcnt_finish) begin
            resume  <= 1'b1;
            state_q <= StGen;
          end
        end
        StCwait: begin
          if (ccnt_finish) begin
            done    <= 1'b1;
            busy    <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_rsp_s2_dma_rd_ctrl.sv
// Self-checking bench for rsp_s2_dma_rd_ctrl: a loop-nest model predicts the descriptor stream,
// a negedge compare process checks every push, directed checks cover handshake timing.
module tb_rsp_s2_dma_rd_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] SLEN = '0;
  logic [11:0] SNUM = '0;
  logic [11:0] FNUM = '0;
  logic [15:0] PBURSTS = '0;
  logic        update, resume, alen_fifo_push, busy, done;
  logic        pcnt_finish = 1'b0;
  logic        ccnt_finish = 1'b0;
  logic        alen_fifo_full = 1'b0;
  logic [11:0] alen_fifo_din;
`ifdef RSP_S2_DMA_RD_CTRL_STAT_EN
  logic [15:0] stat_bursts;
`endif

  int checks = 0;
  int failures = 0;
  logic [11:0] exp_q[$];
  int n_exp;

  always #5 clk = ~clk;

  rsp_s2_dma_rd_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .SLEN           (SLEN),
    .SNUM           (SNUM),
    .FNUM           (FNUM),
    .PBURSTS        (PBURSTS),
    .update         (update),
    .resume         (resume),
    .pcnt_finish    (pcnt_finish),
    .ccnt_finish    (ccnt_finish),
    .alen_fifo_push (alen_fifo_push),
    .alen_fifo_full (alen_fifo_full),
    .alen_fifo_din  (alen_fifo_din),
    .busy           (busy),
    .done           (done)
`ifdef RSP_S2_DMA_RD_CTRL_STAT_EN
    ,
    .stat_bursts    (stat_bursts)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected descriptor stream straight from the loop-nest rules.
  function automatic void build_model(input int slen, input int snum, input int fnum,
                                      input int pb);
    int w, len, pc;
    bit sl, fl, cl, pl;
    exp_q.delete();
    pc = 0;
    if (slen == 0 || snum == 0 || fnum == 0) return;
    for (int f = 0; f < fnum; f++) begin
      for (int s = 0; s < snum; s++) begin
        w = slen;
        while (w > 0) begin
          len = (w < 16) ? w : 16;
          w -= len;
          sl = (w == 0);
          fl = sl && (s == snum - 1);
          cl = fl && (f == fnum - 1);
          pl = 1'b0;
          if (pb != 0) begin
            pc++;
            if (pc == pb) begin
              pl = 1'b1;
              pc = 0;
            end
          end
          if (cl) pl = 1'b0;
          exp_q.push_back({sl, pl, fl, cl, 8'(len - 1)});
        end
      end
    end
    n_exp = exp_q.size();
  endfunction

  // Every push is checked against the model and against the full flag it was decided on.
  always @(negedge clk) begin
    if (rst_n && alen_fifo_push) begin
      if (alen_fifo_full) check("push_while_full", 32'(alen_fifo_full), 32'd0);
      if (exp_q.size() == 0) check("unexpected_push", 32'(alen_fifo_din), 32'hFFFF_FFFF);
      else check("desc", 32'(alen_fifo_din), 32'(exp_q.pop_front()));
    end
  end

  task automatic run_cmd(input int slen, input int snum, input int fnum, input int pb,
                         input int full_at, input int bstart_at);
    int cyc, pw, cw, full_left;
    bit chk_res, chk_push, chk_done, fin;
    cyc = 0; pw = -1; cw = -1; full_left = 0;
    chk_res = 0; chk_push = 0; chk_done = 0; fin = 0;
    build_model(slen, snum, fnum, pb);
    @(negedge clk); #1;
    SLEN = 16'(slen); SNUM = 12'(snum); FNUM = 12'(fnum); PBURSTS = 16'(pb); start = 1'b1;
    @(negedge clk);
    check("update_pulse", 32'(update), 32'd1);
    check("busy_on", 32'(busy), 32'd1);
    check("no_push_in_upd", 32'(alen_fifo_push), 32'd0);
    #1 start = 1'b0;
    while (!fin && cyc < 500) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check("first_push", 32'(alen_fifo_push), 32'd1);
      if (cyc == 1) check("update_once", 32'(update), 32'd0);
      if (chk_res) begin
        check("resume_lat", 32'(resume), 32'd1);
        chk_res = 0;
        chk_push = 1;
      end else if (chk_push) begin
        check("push_after_resume", 32'(alen_fifo_push), 32'd1);
        chk_push = 0;
      end
      if (pw > 0) check("pwait_hold", 32'(alen_fifo_push), 32'd0);
      if (chk_done) begin
        check("done_lat", 32'(done), 32'd1);
        check("busy_off", 32'(busy), 32'd0);
        check("all_pushed", 32'(exp_q.size()), 32'd0);
`ifdef RSP_S2_DMA_RD_CTRL_STAT_EN
        check("stat_bursts", 32'(stat_bursts), 32'(n_exp));
`endif
        fin = 1;
      end
      if (alen_fifo_push && alen_fifo_din[10]) pw = 3;
      if (alen_fifo_push && alen_fifo_din[8]) cw = 2;
      #1;
      start = 1'b0; pcnt_finish = 1'b0; ccnt_finish = 1'b0;
      SLEN = 16'(slen);
      if (pw > 0) begin
        pw--;
        if (pw == 0) begin
          pcnt_finish = 1'b1; chk_res = 1; pw = -1;
        end
      end
      if (cw > 0) begin
        cw--;
        if (cw == 0) begin
          ccnt_finish = 1'b1; chk_done = 1; cw = -1;
        end
      end
      if (cyc == full_at) full_left = 5;
      if (full_left > 0) begin
        alen_fifo_full = 1'b1; full_left--;
      end else begin
        alen_fifo_full = 1'b0;
      end
      if (cyc == bstart_at) begin
        start = 1'b1; SLEN = 16'd3;
      end
    end
    if (!fin) check("timeout", 32'(cyc), 32'd0);
    @(negedge clk);
    check("done_once", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_update", 32'(update), 32'd0);
    check("rst_push", 32'(alen_fifo_push), 32'd0);
    check("rst_din", 32'(alen_fifo_din), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    #1 rst_n = 1'b1;

    // Pin the model with hand-computed streams.
    build_model(40, 1, 1, 0);
    check("model_t1_0", 32'(exp_q[0]), 32'h00F);
    check("model_t1_2", 32'(exp_q[2]), 32'hB07);
    build_model(16, 2, 2, 0);
    check("model_t2_1", 32'(exp_q[1]), 32'hA0F);
    check("model_t2_3", 32'(exp_q[3]), 32'hB0F);
    build_model(16, 4, 1, 2);
    check("model_t3_1", 32'(exp_q[1]), 32'hC0F);
    check("model_t3_3", 32'(exp_q[3]), 32'hB0F);
    exp_q.delete();

    run_cmd(40, 1, 1, 0, -1, -1);
    run_cmd(16, 2, 2, 0, -1, -1);
    run_cmd(16, 4, 1, 2, -1, -1);
    run_cmd(40, 2, 2, 0, 3, 6);
    run_cmd(40, 2, 2, 5, -1, 2);

    // Zero segment count: immediate done, nothing else.
    @(negedge clk); #1;
    SLEN = 16'd8; SNUM = 12'd0; FNUM = 12'd1; PBURSTS = 16'd0; start = 1'b1;
    @(negedge clk);
    check("zero_done", 32'(done), 32'd1);
    check("zero_update", 32'(update), 32'd0);
    check("zero_push", 32'(alen_fifo_push), 32'd0);
    check("zero_busy", 32'(busy), 32'd0);
    #1 start = 1'b0;
    @(negedge clk);
    check("zero_done_once", 32'(done), 32'd0);
    check("zero_still_idle", 32'(update), 32'd0);

    // Reset in the middle of a long stream, then a fresh command.
    build_model(64, 1, 1, 0);
    @(negedge clk); #1;
    SLEN = 16'd64; SNUM = 12'd1; FNUM = 12'd1; start = 1'b1;
    @(negedge clk); #1 start = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("mid_rst_push", 32'(alen_fifo_push), 32'd0);
    check("mid_rst_din", 32'(alen_fifo_din), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_update", 32'(update), 32'd0);
`ifdef RSP_S2_DMA_RD_CTRL_STAT_EN
    check("mid_rst_stat", 32'(stat_bursts), 32'd0);
`endif
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_push", 32'(alen_fifo_push), 32'd0);
    run_cmd(16, 2, 2, 0, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
